// File: rtl/apb_bus_pkg.sv
// Shared definitions for the two-port APB bus arbiter: state encoding,
// address-map defaults and the address-decode helper.
package apb_bus_pkg;

   // Default peripheral window: MAP_SLOTS_DEFAULT slots of SLOT_SIZE bytes from MAP_BASE_DEFAULT
   localparam logic [31:0] MAP_BASE_DEFAULT  = 32'h1000_0000;
   localparam int unsigned MAP_SLOTS_DEFAULT = 6;
   localparam int unsigned SLOT_SIZE         = 4096;

   // Arbiter FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE        = 3'd0;
   localparam state_t ST_CHECK       = 3'd1;
   localparam state_t ST_ISSUE       = 3'd2;
   localparam state_t ST_SETUP_WAIT  = 3'd3;
   localparam state_t ST_ACCESS_WAIT = 3'd4;
   localparam state_t ST_RESP        = 3'd5;

   // True when addr falls inside [base, base + slots*SLOT_SIZE). Evaluated on
   // 33 bits so a window reaching the top of the address space cannot wrap.
   function automatic logic addr_mapped(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned slots);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + (33'(slots) * 33'(SLOT_SIZE));
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant. The winner is combinational from the request
// lines; the last-grant pointer only moves when the caller reports a
// completed grant through update/update_idx.
module apb_rr_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic update,
   input  logic update_idx,
   output logic valid,
   output logic idx
);

   logic last;

   // Pick the winner: a lone requester wins, a tie goes to the port not granted last
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         idx = ~last;
      end else begin
         idx = req1;
      end
   end

   // Track the most recently completed grant; resets to port 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (update) begin
         last <= update_idx;
      end
   end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two requester ports sharing one APB master. A request is granted in IDLE,
// its address is decoded in CHECK, mapped accesses are launched with a
// one-cycle transfer pulse and completed on the master's ready; unmapped
// accesses are answered with err without touching the bus.
module apb_bus_arbiter
   import apb_bus_pkg::*;
#(
   parameter logic [31:0] MAP_BASE  = MAP_BASE_DEFAULT,
   parameter int unsigned MAP_SLOTS = MAP_SLOTS_DEFAULT
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        m0_req,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        transfer,
   output logic        write,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        ready,
   input  logic [31:0] rdata
);

   state_t      state;
   state_t      state_nxt;
   logic        grant;
   logic        err_q;
   logic        arb_valid;
   logic        arb_idx;
   logic        in_resp;
   logic        mapped;
   logic        load_rdata;
   logic [31:0] resp_data;

   assign in_resp = (state == ST_RESP);
   assign mapped  = addr_mapped(addr, MAP_BASE, MAP_SLOTS);

   apb_rr_arbiter u_rr (
      .clk        (PCLK),
      .rst_n      (PRESET),
      .req0       (m0_req),
      .req1       (m1_req),
      .update     (in_resp),
      .update_idx (grant),
      .valid      (arb_valid),
      .idx        (arb_idx)
   );

   // Next-state decode; ready only counts once the master is in its ACCESS phase
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:        if (arb_valid) state_nxt = ST_CHECK;
         ST_CHECK:       state_nxt = mapped ? ST_ISSUE : ST_RESP;
         ST_ISSUE:       state_nxt = ST_SETUP_WAIT;
         ST_SETUP_WAIT:  state_nxt = ST_ACCESS_WAIT;
         ST_ACCESS_WAIT: if (ready) state_nxt = ST_RESP;
         ST_RESP:        state_nxt = ST_IDLE;
         default:        state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, granted port, latched request fields and the err decision
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state <= ST_IDLE;
         grant <= 1'b0;
         err_q <= 1'b0;
         write <= 1'b0;
         addr  <= 32'd0;
         wdata <= 32'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && arb_valid) begin
            grant <= arb_idx;
            write <= arb_idx ? m1_write : m0_write;
            addr  <= arb_idx ? m1_addr  : m0_addr;
            wdata <= arb_idx ? m1_wdata : m0_wdata;
         end
         if (state == ST_CHECK) begin
            err_q <= ~mapped;
         end
      end
   end

   // Response data: slave data for a completed read, zero for writes and rejected accesses
   always_comb begin
      load_rdata = ((state == ST_ACCESS_WAIT) && ready) || ((state == ST_CHECK) && !mapped);
      resp_data  = ((state == ST_ACCESS_WAIT) && !write) ? rdata : 32'd0;
   end

   // Per-port read data, loaded on the edge into RESP and held until that port's next done
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         m0_rdata <= 32'd0;
         m1_rdata <= 32'd0;
      end else if (load_rdata) begin
         if (grant) begin
            m1_rdata <= resp_data;
         end else begin
            m0_rdata <= resp_data;
         end
      end
   end

   // Outputs decoded straight from registered state, so they drop the moment reset asserts
   always_comb begin
      transfer = (state == ST_ISSUE);
      m0_done  = in_resp && !grant;
      m1_done  = in_resp &&  grant;
      m0_err   = m0_done && err_q;
      m1_err   = m1_done && err_q;
   end

endmodule
